digital_clock_hms: RTL and testbench

- Parametrised successor to the minutes/seconds digital clock.
- Keeps hours, minutes and seconds, with an internal prescaler so it runs from a fast system clock.
- Any one field (sec/min/hour) can be selected and stepped up or down with the increment and decrement pushbuttons.
- Hours can be presented in 24 h or 12 h+PM format; the block feeds the display/decoder stage.

---
 rtl/digital_clock_hms.sv | 106 ++++++++++
 tb/tb_digital_clock_hms.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/digital_clock_hms.sv
// Hours/minutes/seconds clock with a one-second prescaler, per-field set
// stepping from debounced pushbuttons, and 24 h or 12 h+PM hour presentation.
module digital_clock_hms #(
  parameter int CLK_DIV  = 1,
  parameter int MODE_12H = 0,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       incr_pb,
  input  logic       decr_pb,
  input  logic [1:0] set_sel,
  output logic [5:0] sec_binary,
  output logic [5:0] min_binary,
  output logic [4:0] hour_binary,
  output logic       pm_flag,
  output logic       tick_1s
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             incr_q, decr_q;
  logic             inc_edge, dec_edge;

  // Wrapping step within a single field; no carry or borrow leaves the field.
  function automatic logic [5:0] step_field(input logic [5:0] v,
                                            input logic [5:0] max_v,
                                            input logic       up);
    if (up) return (v == max_v) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

  assign inc_edge = incr_pb & ~incr_q;
  assign dec_edge = decr_pb & ~decr_q;

  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (set_sel == 2'b00) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sec_d  = step_field(sec_q, 6'd59, 1'b1);
        if (sec_q == 6'd59) begin
          min_d = step_field(min_q, 6'd59, 1'b1);
          if (min_q == 6'd59)
            hour_d = 5'(step_field({1'b0, hour_q}, 6'd23, 1'b1));
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
      // Simultaneous up and down edges cancel out.
      if (inc_edge ^ dec_edge) begin
        case (set_sel)
          2'b01:   sec_d  = step_field(sec_q, 6'd59, inc_edge);
          2'b10:   min_d  = step_field(min_q, 6'd59, inc_edge);
          default: hour_d = 5'(step_field({1'b0, hour_q}, 6'd23, inc_edge));
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      incr_q <= 1'b0;
      decr_q <= 1'b0;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      incr_q <= incr_pb;
      decr_q <= decr_pb;
    end
  end

  always_comb begin
    hour_binary = hour_q;
    if (MODE_12H != 0) begin
      if (hour_q == 5'd0)      hour_binary = 5'd12;
      else if (hour_q > 5'd12) hour_binary = hour_q - 5'd12;
    end
  end

  assign pm_flag    = (hour_q >= 5'd12);
  assign sec_binary = sec_q;
  assign min_binary = min_q;
  assign tick_1s    = tick_q;

endmodule

// File: tb/tb_digital_clock_hms.sv
// Scoreboard bench: stimulus queues hand-computed expectations tagged with the
// cycle they apply to; a monitor compares both clock variants at that cycle.
module tb_digital_clock_hms;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       incr_pb = 1'b0;
  logic       decr_pb = 1'b0;
  logic [1:0] set_sel = 2'b00;
  logic [5:0] sec0, min0, sec1, min1;
  logic [4:0] hour0, hour1;
  logic       pm0, pm1, tick0, tick1;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    string nm;
    int    cyc;
    int    s, m, h, p, t, h12;
  } exp_t;
  exp_t q[$];

  digital_clock_hms #(.CLK_DIV(4), .MODE_12H(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .incr_pb(incr_pb), .decr_pb(decr_pb),
    .set_sel(set_sel), .sec_binary(sec0), .min_binary(min0),
    .hour_binary(hour0), .pm_flag(pm0), .tick_1s(tick0)
  );

  digital_clock_hms #(.CLK_DIV(4), .MODE_12H(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .incr_pb(incr_pb), .decr_pb(decr_pb),
    .set_sel(set_sel), .sec_binary(sec1), .min_binary(min1),
    .hour_binary(hour1), .pm_flag(pm1), .tick_1s(tick1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due at this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        total++;
        if (e.cyc < cyc) begin
          bad++;
          $display("FAIL %s: check due at cycle %0d missed (now %0d)", e.nm, e.cyc, cyc);
        end else if (sec0 != 6'(e.s) || min0 != 6'(e.m) || hour0 != 5'(e.h) ||
                     pm0 != 1'(e.p) || tick0 != 1'(e.t) ||
                     hour1 != 5'(e.h12) || pm1 != 1'(e.p) || tick1 != 1'(e.t)) begin
          bad++;
          $display("FAIL %s @%0d: got %0d:%0d:%0d pm=%0d tick=%0d h12=%0d pm12=%0d tick12=%0d, want %0d:%0d:%0d pm=%0d tick=%0d h12=%0d",
                   e.nm, cyc, hour0, min0, sec0, pm0, tick0, hour1, pm1, tick1,
                   e.h, e.m, e.s, e.p, e.t, e.h12);
        end
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp(input int dc, input string nm, input int s, input int m,
                     input int h, input int p, input int t, input int h12);
    exp_t e;
    e.nm = nm; e.cyc = cyc + dc;
    e.s = s; e.m = m; e.h = h; e.p = p; e.t = t; e.h12 = h12;
    q.push_back(e);
  endtask

  task automatic press(input logic inc, input logic dec);
    incr_pb = inc;
    decr_pb = dec;
    tick_n(1);
    incr_pb = 1'b0;
    decr_pb = 1'b0;
    tick_n(1);
  endtask

  initial begin
    tick_n(2);
    exp(1, "reset_state", 0, 0, 0, 0, 0, 12);
    tick_n(1);

    // Free run for 240 cycles: tick every 4th cycle, 60 ticks -> 00:01:00.
    reset = 1'b1;
    for (int i = 1; i <= 240; i++)
      exp(i, "run", (i / 4) % 60, i / 240, 0, 0, (i % 4 == 0) ? 1 : 0, 12);
    tick_n(240);

    // Preload 23:59:59; set_sel change and press on the same edge.
    set_sel = 2'b01;
    exp(1, "sec_dn_wrap_same_edge", 59, 1, 0, 0, 0, 12);
    press(1'b0, 1'b1);
    set_sel = 2'b10;
    exp(1, "min_dn", 59, 0, 0, 0, 0, 12);
    press(1'b0, 1'b1);
    exp(1, "min_dn_wrap", 59, 59, 0, 0, 0, 12);
    press(1'b0, 1'b1);
    set_sel = 2'b11;
    exp(1, "hour_dn_wrap", 59, 59, 23, 1, 0, 11);
    press(1'b0, 1'b1);

    // Back to run: first tick CLK_DIV cycles later rolls over to midnight.
    set_sel = 2'b00;
    for (int dc = 1; dc <= 3; dc++) exp(dc, "pre_roll", 59, 59, 23, 1, 0, 11);
    exp(4, "rollover", 0, 0, 0, 0, 1, 12);
    exp(5, "post_roll", 0, 0, 0, 0, 0, 12);
    tick_n(5);

    // Minutes: set 59, hold incr for 30 cycles -> one step only.
    set_sel = 2'b10;
    exp(1, "min_set59", 0, 59, 0, 0, 0, 12);
    press(1'b0, 1'b1);
    incr_pb = 1'b1;
    for (int dc = 1; dc <= 30; dc++) exp(dc, "min_held", 0, 0, 0, 0, 0, 12);
    tick_n(30);
    incr_pb = 1'b0;
    tick_n(1);
    exp(1, "min_dn_wrap2", 0, 59, 0, 0, 0, 12);
    press(1'b0, 1'b1);

    // Hours: borrow-free wrap down, cancelling edges, wrap up.
    set_sel = 2'b11;
    exp(1, "hour_dn_wrap2", 0, 59, 23, 1, 0, 11);
    press(1'b0, 1'b1);
    exp(1, "both_edges", 0, 59, 23, 1, 0, 11);
    press(1'b1, 1'b1);
    exp(1, "hour_up_wrap", 0, 59, 0, 0, 0, 12);
    press(1'b1, 1'b0);

    // 12 h mapping checkpoints at hours 11, 12, 13, 23.
    repeat (10) press(1'b1, 1'b0);
    exp(1, "h11", 0, 59, 11, 0, 0, 11);
    press(1'b1, 1'b0);
    exp(1, "h12", 0, 59, 12, 1, 0, 12);
    press(1'b1, 1'b0);
    exp(1, "h13", 0, 59, 13, 1, 0, 1);
    press(1'b1, 1'b0);
    repeat (9) press(1'b1, 1'b0);
    exp(1, "h23", 0, 59, 23, 1, 0, 11);
    press(1'b1, 1'b0);

    // Load 05:10:20.
    set_sel = 2'b01;
    repeat (19) press(1'b1, 1'b0);
    exp(1, "sec20", 20, 59, 23, 1, 0, 11);
    press(1'b1, 1'b0);
    set_sel = 2'b10;
    repeat (10) press(1'b1, 1'b0);
    exp(1, "min10", 20, 10, 23, 1, 0, 11);
    press(1'b1, 1'b0);
    set_sel = 2'b11;
    repeat (5) press(1'b1, 1'b0);
    exp(1, "hour5", 20, 10, 5, 0, 0, 5);
    press(1'b1, 1'b0);

    // Run to prescaler=2 with incr held (ignored), then reset for one edge.
    set_sel = 2'b00;
    incr_pb = 1'b1;
    exp(1, "run_ignores_pb", 20, 10, 5, 0, 0, 5);
    exp(2, "run_ignores_pb2", 20, 10, 5, 0, 0, 5);
    tick_n(2);
    reset = 1'b0;
    exp(1, "mid_reset", 0, 0, 0, 0, 0, 12);
    tick_n(1);
    reset = 1'b1;
    exp(1, "post_reset_run", 0, 0, 0, 0, 0, 12);
    tick_n(1);
    set_sel = 2'b01;
    for (int dc = 1; dc <= 5; dc++) exp(dc, "held_no_step", 0, 0, 0, 0, 0, 12);
    tick_n(5);
    incr_pb = 1'b0;
    tick_n(1);
    exp(1, "fresh_press", 1, 0, 0, 0, 0, 12);
    press(1'b1, 1'b0);

    tick_n(2);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
